// File: rtl/decoder_2to4.sv
// decoder_2to4: registered 2-to-4 one-hot select decoder.
// Ports: clk, rst (sync, active-high), en, a (MSB), b (LSB) -> d[3:0], d_valid.
module decoder_2to4 #(
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter bit IDLE_ON_DISABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  output logic [3:0] d,
  output logic       d_valid
);

  localparam logic [3:0] POL  = {4{ACTIVE_LOW}};
  localparam logic [3:0] IDLE = POL;

  logic [1:0] sel;
  logic [3:0] hot;
  logic [3:0] dec;

  assign sel = {a, b};

  always_comb begin
    hot = 4'b0000;
    unique case (1'b1)
      sel == 2'd0: hot = 4'b0001;
      sel == 2'd1: hot = 4'b0010;
      sel == 2'd2: hot = 4'b0100;
      sel == 2'd3: hot = 4'b1000;
    endcase
  end

  // XOR with the polarity mask gives the active-low variant.
  assign dec = hot ^ POL;

  always_ff @(posedge clk) begin
    if (rst) begin
      d       <= IDLE;
      d_valid <= 1'b0;
    end else if (en) begin
      d       <= dec;
      d_valid <= 1'b1;
    end else begin
      d_valid <= 1'b0;
      if (IDLE_ON_DISABLE)
        d <= IDLE;
    end
  end

endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: directed checks on three decoder builds.
// Default, hold-on-disable and active-low instances share stimulus.
module tb_decoder_2to4;

  logic       clk = 1'b0;
  logic       rst, en, a, b;
  logic [3:0] d_hi, d_hold, d_lo;
  logic       v_hi, v_hold, v_lo;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_2to4 #(.ACTIVE_LOW(1'b0), .IDLE_ON_DISABLE(1'b1)) u_hi (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .d(d_hi), .d_valid(v_hi)
  );

  decoder_2to4 #(.ACTIVE_LOW(1'b0), .IDLE_ON_DISABLE(1'b0)) u_hold (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .d(d_hold), .d_valid(v_hold)
  );

  decoder_2to4 #(.ACTIVE_LOW(1'b1), .IDLE_ON_DISABLE(1'b1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .d(d_lo), .d_valid(v_lo)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 4'b0001;
    sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b0100;
    sweep_exp[3] = 4'b1000;

    rst = 1'b1; en = 1'b1; a = 1'b1; b = 1'b1;

    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_d",    {4'h0, d_hi},   8'h00);
      check("rst_v",    {7'h0, v_hi},   8'h00);
      check("rst_hold", {4'h0, d_hold}, 8'h00);
      check("rst_lo",   {4'h0, d_lo},   8'h0F);
      check("rst_v_lo", {7'h0, v_lo},   8'h00);
    end

    rst = 1'b0;
    tick();
    check("rel_d",  {4'h0, d_hi}, 8'b0000_1000);
    check("rel_v",  {7'h0, v_hi}, 8'h01);
    check("rel_lo", {4'h0, d_lo}, 8'b0000_0111);

    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      tick();
      check($sformatf("sw_d%0d", i),   {4'h0, d_hi},   {4'h0, sweep_exp[i]});
      check($sformatf("sw_v%0d", i),   {7'h0, v_hi},   8'h01);
      check($sformatf("sw_1h%0d", i),  8'($countones(d_hi)), 8'd1);
      check($sformatf("sw_lo%0d", i),  {4'h0, d_lo},   {4'h0, ~sweep_exp[i]});
      check($sformatf("sw_hd%0d", i),  {4'h0, d_hold}, {4'h0, sweep_exp[i]});
    end

    {a, b} = 2'b10;
    tick();
    check("pre_dis", {4'h0, d_hi}, 8'b0000_0100);

    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("dis_d",    {4'h0, d_hi},   8'h00);
      check("dis_v",    {7'h0, v_hi},   8'h00);
      check("dis_hold", {4'h0, d_hold}, 8'b0000_0100);
      check("dis_hv",   {7'h0, v_hold}, 8'h00);
      check("dis_lo",   {4'h0, d_lo},   8'h0F);
    end

    en = 1'b1;
    tick();
    check("reen_d", {4'h0, d_hi}, 8'b0000_0100);
    check("reen_v", {7'h0, v_hi}, 8'h01);

    #2; a = 1'b0; b = 1'b1;
    #1; check("glitch_mid", {4'h0, d_hi}, 8'b0000_0100);
    #1; a = 1'b1; b = 1'b0;
    tick();
    check("glitch_d", {4'h0, d_hi}, 8'b0000_0100);
    check("glitch_v", {7'h0, v_hi}, 8'h01);

    rst = 1'b1;
    tick();
    check("mrst_d",  {4'h0, d_hi},   8'h00);
    check("mrst_v",  {7'h0, v_hi},   8'h00);
    check("mrst_hd", {4'h0, d_hold}, 8'h00);
    check("mrst_lo", {4'h0, d_lo},   8'h0F);

    rst = 1'b0;
    tick();
    check("post_d",  {4'h0, d_hi}, 8'b0000_0100);
    check("post_v",  {7'h0, v_hi}, 8'h01);
    check("post_lo", {4'h0, d_lo}, 8'b0000_1011);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_2to4.md
Name: decoder_2to4

Overview:
- Registered 2-to-4 line one-hot decoder.
- Two select bits {a,b} (a = MSB) drive exactly one of four outputs active, one clock after sampling.
- Used as a small address/select decoder in synchronous datapaths.
- Carries an enable input and an output-valid flag so downstream logic can qualify the one-hot word.

Parameters:
- ACTIVE_LOW, 0: when 1, the outputs d are inverted. The selected line is driven 0 and the idle value is 4'b1111.
- IDLE_ON_DISABLE, 1: when 1, en=0 drives d to the idle value. When 0, en=0 holds the previous d.

Ports:
- clk      input   1  rising-edge clock; the only clock domain.
- rst      input   1  synchronous, active-high reset, sampled on the rising clk edge.
- en       input   1  decode enable, sampled each clock.
- a        input   1  select MSB.
- b        input   1  select LSB.
- d        output  4  registered one-hot decode output (polarity set by ACTIVE_LOW).
- d_valid  output  1  high when d holds a decode from the previous enabled cycle.

Behaviour:
- Select index sel = {a,b}; 0..3.
- Mapping with ACTIVE_LOW=0:
  - sel 0 -> d=4'b0001
  - sel 1 -> d=4'b0010
  - sel 2 -> d=4'b0100
  - sel 3 -> d=4'b1000
- ACTIVE_LOW=1 gives the bitwise inverse of the above.
- Latency: one cycle. Inputs sampled at rising edge N appear on d at edge N; they are visible after that edge and stable for cycle N+1.
- Reset takes priority over everything. On a rising edge with rst=1:
  - d = idle value (4'b0000, or 4'b1111 if ACTIVE_LOW)
  - d_valid = 0
- No asynchronous reset path.
- en=1 (rst=0): d loads the decode of the sampled {a,b}; d_valid=1.
- en=0 (rst=0):
  - d_valid=0.
  - d goes to the idle value if IDLE_ON_DISABLE=1, else holds its last value.
- Invariant with ACTIVE_LOW=0: d has exactly one bit set whenever d_valid=1, and is zero after reset.
- Select changes between edges have no effect; only the values at the rising edge matter.
- Reset mid-stream: if rst=1 coincides with en=1, the reset wins. The following cycle with rst=0, en=1 decodes normally, so no warm-up cycle is required.
- X/Z on a, b or en are not required to be handled; outputs are defined only for 0/1 inputs.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: rst=1 for 2 clocks with en=1, a=1, b=1 -> d=4'b0000 and d_valid=0 after each edge. Release rst -> next edge gives d=4'b1000, d_valid=1.
- Full sweep, en=1, one value per clock, {a,b}=00,01,10,11 -> d=0001, 0010, 0100, 1000 on successive edges, d_valid=1 throughout. Check that exactly one bit is set each cycle.
- Disable: after d=4'b0100, set en=0.
  - IDLE_ON_DISABLE=1 -> d=4'b0000, d_valid=0 next edge.
  - IDLE_ON_DISABLE=0 -> d stays 4'b0100, d_valid=0.
- Mid-cycle glitch: toggle a, b between edges and restore them before the edge -> d reflects only the edge-sampled value; no change visible on d.
- Active-low build (ACTIVE_LOW=1): reset -> d=4'b1111. Then {a,b}=01 with en=1 -> d=4'b1101; {a,b}=11 -> d=4'b0111.
- Reset during operation: steady {a,b}=10, en=1 (d=4'b0100); assert rst one cycle -> d=0000, d_valid=0; deassert -> d=4'b0100, d_valid=1 on the following edge.
